// File: rtl/pipeline_stall_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: stall/flush steering,
// multi-cycle multiply/divide busy tracking and a saturating stall-cycle counter.
module pipeline_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic                  ex_mem_read,
    input  logic [4:0]            ex_rt,
    input  logic                  ex_branch_taken,
    input  logic                  id_jump,
    input  logic                  id_md_start,
    input  logic                  id_reads_hilo,
    input  logic                  mem_ready,
    input  logic                  clr_stats,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_flush,
    output logic                  md_issue,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [STAT_WIDTH-1:0] stall_cycles
);

    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    md_state_e             md_state_q, md_state_d;
    logic [CNT_W-1:0]      md_cnt_q, md_cnt_d;
    logic [STAT_WIDTH-1:0] stall_q, stall_d;

    logic load_use;
    logic md_hz;
    logic id_hz;

    // Hazard detection for the instruction sitting in ID
    always_comb begin
        load_use = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        md_hz    = (md_state_q == MD_RUN) && (id_md_start || id_reads_hilo);
        id_hz    = load_use || md_hz;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
            stall_q    <= '0;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // MD next state: the counter runs regardless of memory waits or flushes
    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        case (md_state_q)
            MD_IDLE: begin
                if (md_issue) begin
                    md_state_d = MD_RUN;
                    md_cnt_d   = CNT_W'(MD_LATENCY);
                end
            end
            MD_RUN: begin
                md_cnt_d = md_cnt_q - CNT_W'(1);
                if (md_cnt_q == CNT_W'(1)) begin
                    md_state_d = MD_IDLE;
                end
            end
            default: begin
                md_state_d = MD_IDLE;
                md_cnt_d   = '0;
            end
        endcase
    end

    // Pipeline controls in priority order; everything is forced low during reset
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        md_issue     = 1'b0;
        md_busy      = 1'b0;
        md_done      = 1'b0;
        if (!reset) begin
            md_busy = (md_state_q == MD_RUN);
            md_done = (md_state_q == MD_RUN) && (md_cnt_q == CNT_W'(1));
            if (!mem_ready) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (id_hz) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                if_id_flush = id_jump;
                md_issue    = id_md_start;
            end
        end
    end

    // Saturating stall counter; clear wins over increment
    always_comb begin
        stall_d = stall_q;
        if (clr_stats) begin
            stall_d = '0;
        end else if (pc_stall && (stall_q != '1)) begin
            stall_d = stall_q + STAT_WIDTH'(1);
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

    localparam int unsigned LAT  = 4;
    localparam int unsigned SW   = 4;
    localparam int unsigned SMAX = (1 << SW) - 1;

    logic          clk;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_mem_read, ex_branch_taken, id_jump, id_md_start, id_reads_hilo;
    logic          mem_ready, clr_stats;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_stall, mem_wb_flush, md_issue, md_busy, md_done;
    logic [SW-1:0] stall_cycles;
    logic [7:0]    ctl;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl #(.MD_LATENCY(LAT), .STAT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .id_md_start(id_md_start),
        .id_reads_hilo(id_reads_hilo), .mem_ready(mem_ready), .clr_stats(clr_stats),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .md_issue(md_issue), .md_busy(md_busy),
        .md_done(md_done), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                  id_ex_flush, ex_mem_stall, mem_wb_flush, md_issue};

    typedef struct {
        logic [4:0] rs, rt, exrt;
        logic       mr, br, jmp, mds, hilo, rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    // Reference model: cycles of MD work remaining and the stall count as plain integers
    int busy_left;
    int stat_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; id_jump = 1'b0;
        id_md_start = 1'b0; id_reads_hilo = 1'b0; mem_ready = 1'b1; clr_stats = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        busy_left = 0;
        stat_cnt  = 0;
    endtask

    function automatic logic [7:0] model_ctl();
        logic lu, hz, iss;
        lu  = ex_mem_read && (ex_rt != 0) && (ex_rt == id_rs || ex_rt == id_rt);
        hz  = lu || (busy_left > 0 && (id_md_start || id_reads_hilo));
        iss = id_md_start && mem_ready && !ex_branch_taken && !hz;
        if (!mem_ready)           return 8'b1101_0110;
        else if (ex_branch_taken) return 8'b0010_1000;
        else if (hz)              return 8'b1100_1000;
        else                      return {2'b00, id_jump, 4'b0000, iss};
    endfunction

    task automatic model_step(input logic [7:0] c);
        if (c[0]) busy_left = LAT;
        else if (busy_left > 0) busy_left--;
        if (clr_stats) stat_cnt = 0;
        else if (c[7]) stat_cnt = (stat_cnt + 1 > SMAX) ? SMAX : stat_cnt + 1;
    endtask

    function automatic vec_t mk(input int rs, input int rt, input int exrt, input logic mr,
                                input logic br, input logic jmp, input logic mds,
                                input logic hilo, input logic rdy, input logic [7:0] exp);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.exrt = 5'(exrt); v.mr = mr; v.br = br;
        v.jmp = jmp; v.mds = mds; v.hilo = hilo; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    initial begin
        logic [7:0] e;
        logic       seen;
        vecs[0]  = mk(5, 0, 5, 1, 0, 0, 0, 0, 1, 8'b1100_1000);
        vecs[1]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 8'b0000_0000);
        vecs[2]  = mk(3, 7, 7, 1, 0, 0, 0, 0, 1, 8'b1100_1000);
        vecs[3]  = mk(5, 0, 5, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
        vecs[4]  = mk(5, 0, 5, 1, 1, 0, 0, 0, 1, 8'b0010_1000);
        vecs[5]  = mk(1, 2, 3, 1, 0, 1, 0, 0, 1, 8'b0010_0000);
        vecs[6]  = mk(9, 2, 9, 1, 0, 1, 0, 0, 1, 8'b1100_1000);
        vecs[7]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 8'b1101_0110);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 8'b0010_1000);
        vecs[9]  = mk(4, 0, 4, 1, 0, 0, 1, 0, 1, 8'b1100_1000);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 8'b1101_0110);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'b0000_0000);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 8'b0000_0001);

        idle_inputs();
        reset = 1'b1;
        #12;
        check("reset_ctl", 32'(ctl), 32'h0);
        check("reset_busy", 32'(md_busy), 32'h0);
        check("reset_stat", 32'(stall_cycles), 32'h0);
        do_reset();

        // Directed vectors with the MD unit idle
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rt = vecs[i].exrt;
            ex_mem_read = vecs[i].mr; ex_branch_taken = vecs[i].br; id_jump = vecs[i].jmp;
            id_md_start = vecs[i].mds; id_reads_hilo = vecs[i].hilo; mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
        end

        // Single load-use stall counts one cycle
        do_reset();
        id_rs = 5'd5; ex_rt = 5'd5; ex_mem_read = 1'b1;
        @(posedge clk); #1;
        check("lu_stat", 32'(stall_cycles), 32'd1);
        @(negedge clk);
        ex_branch_taken = 1'b1;
        @(posedge clk); #1;
        check("br_lu_stat", 32'(stall_cycles), 32'd1);

        // MD issue, busy window, done pulse and HI/LO reader release
        do_reset();
        id_md_start = 1'b1;
        #1;
        check("md_issue_c0", 32'(md_issue), 32'd1);
        check("md_busy_c0", 32'(md_busy), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            id_md_start = 1'b0; id_reads_hilo = 1'b1;
            #1;
            check($sformatf("md_busy_c%0d", c), 32'(md_busy), 32'(c <= 4));
            check($sformatf("md_done_c%0d", c), 32'(md_done), 32'(c == 4));
            check($sformatf("md_stall_c%0d", c), 32'(pc_stall), 32'(c <= 4));
        end
        check("md_stat", 32'(stall_cycles), 32'd4);

        // Memory wait with pending jump while MD counts down
        do_reset();
        id_md_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            id_md_start = 1'b0; id_jump = 1'b1; mem_ready = (c == 4);
            #1;
            check($sformatf("mw_ctl_c%0d", c), 32'(ctl),
                  (c == 4) ? 32'h20 : 32'hD6);
            check($sformatf("mw_done_c%0d", c), 32'(md_done), 32'(c == 4));
        end

        // Asynchronous reset during MD run aborts without a done pulse
        do_reset();
        id_md_start = 1'b1;
        @(negedge clk);
        id_md_start = 1'b0; id_reads_hilo = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(md_busy), 32'd0);
        check("rst_mid_stat", 32'(stall_cycles), 32'd0);
        check("rst_mid_ctl", 32'(ctl), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            seen = seen | md_done | md_busy;
        end
        check("rst_no_done", 32'(seen), 32'd0);

        // Saturation and clear-over-increment
        do_reset();
        id_rs = 5'd6; ex_rt = 5'd6; ex_mem_read = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("sat_stat", 32'(stall_cycles), 32'(SMAX));
        @(negedge clk);
        clr_stats = 1'b1;
        @(posedge clk); #1;
        check("clr_stat", 32'(stall_cycles), 32'd0);

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            ex_mem_read = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_jump = ($urandom_range(0, 5) == 0);
            id_md_start = ($urandom_range(0, 4) == 0);
            id_reads_hilo = ($urandom_range(0, 3) == 0);
            mem_ready = ($urandom_range(0, 6) != 0);
            clr_stats = ($urandom_range(0, 40) == 0);
            #1;
            e = model_ctl();
            check("rnd_ctl", 32'(ctl), 32'(e));
            check("rnd_busy", 32'(md_busy), 32'(busy_left > 0));
            check("rnd_done", 32'(md_done), 32'(busy_left == 1));
            @(posedge clk);
            model_step(e);
            #1;
            check("rnd_stat", 32'(stall_cycles), 32'(stat_cnt));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
